// File: rtl/vin_timing_detect_if.sv
// Video input and measured-timing bundle for vin_timing_detect.
// The detector uses the slave view; the pin/receiver side uses the master view.
interface vin_timing_detect_if;
    logic        vin_hs;
    logic        vin_vs;
    logic        vin_de;
    logic [15:0] h_total;
    logic [15:0] h_active;
    logic [15:0] v_total;
    logic [15:0] v_active;
    logic        hs_pol;
    logic        vs_pol;
    logic        locked;
    logic        timing_change;
    logic        frame_start;

    modport master (
        output vin_hs, vin_vs, vin_de,
        input  h_total, h_active, v_total, v_active,
        input  hs_pol, vs_pol, locked, timing_change, frame_start
    );

    modport slave (
        input  vin_hs, vin_vs, vin_de,
        output h_total, h_active, v_total, v_active,
        output hs_pol, vs_pol, locked, timing_change, frame_start
    );
endinterface

// File: rtl/vin_timing_detect.sv
// Measures incoming hs/vs/de timing per frame and locks after LOCK_FRAMES identical frames.
// Define VIN_TIMING_POL_DETECT_EN to auto-detect sync polarity; otherwise both syncs are taken as active-high.
module vin_timing_detect #(
    parameter int unsigned LOCK_FRAMES = 3,
    parameter logic [23:0] TIMEOUT     = 24'd4_000_000
) (
    input  logic                clk,
    input  logic                rst,
    vin_timing_detect_if.slave  vif
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [3:0] LOCK_N     = 4'(LOCK_FRAMES);

    logic        hs1, vs1, de1, hs2, vs2, de2;
    logic        hs_pol_q, vs_pol_q, pol_chg;
    logic        hs_edge, vs_edge, hs_lead, vs_lead;
    logic [1:0]  state;
    logic [15:0] h_cnt, de_cnt, line_cnt, act_cnt;
    logic [15:0] cand_ht, cand_ha, cand_vt, cand_va;
    logic [15:0] prev_ht, prev_ha, prev_vt, prev_va;
    logic [15:0] out_ht, out_ha, out_vt, out_va;
    logic        prev_valid, geom_eq, locked_q, tchg_q;
    logic [3:0]  stable_cnt, stable_nxt;
    logic [23:0] to_cnt;

    always_comb begin
        hs_edge = (hs1 ^ ~hs_pol_q) & ~(hs2 ^ ~hs_pol_q);
        vs_edge = (vs1 ^ ~vs_pol_q) & ~(vs2 ^ ~vs_pol_q);
    end

    // Edge pulses are registered, so hs_lead/vs_lead line up with de2 and vs_lead doubles as frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            {hs1, vs1, de1, hs2, vs2, de2} <= '0;
            hs_lead <= 1'b0;
            vs_lead <= 1'b0;
            h_cnt   <= '0;
            de_cnt  <= '0;
            cand_ht <= '0;
            cand_ha <= '0;
            to_cnt  <= '0;
        end else begin
            hs1 <= vif.vin_hs;
            vs1 <= vif.vin_vs;
            de1 <= vif.vin_de;
            hs2 <= hs1;
            vs2 <= vs1;
            de2 <= de1;
            hs_lead <= hs_edge;
            vs_lead <= vs_edge;
            if (hs_lead) begin
                h_cnt   <= 16'd1;
                de_cnt  <= {15'd0, de2};
                cand_ht <= h_cnt;
                if (de_cnt != '0) cand_ha <= de_cnt;
            end else begin
                if (h_cnt != '1) h_cnt <= h_cnt + 16'd1;
                if (de2 && de_cnt != '1) de_cnt <= de_cnt + 16'd1;
            end
            if (vs_lead) to_cnt <= '0;
            else if (to_cnt != TIMEOUT) to_cnt <= to_cnt + 24'd1;
        end
    end

    always_comb begin
        geom_eq = prev_valid && cand_ht == prev_ht && cand_ha == prev_ha &&
                  cand_vt == prev_vt && cand_va == prev_va;
        if (pol_chg)                 stable_nxt = '0;
        else if (!geom_eq)           stable_nxt = 4'd1;
        else if (stable_cnt >= LOCK_N) stable_nxt = LOCK_N;
        else                         stable_nxt = stable_cnt + 4'd1;
    end

    // The line closed by the hs edge that coincides with vs belongs to the old frame for v_active,
    // while that hs edge itself opens line 1 of the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            line_cnt   <= '0;
            act_cnt    <= '0;
            cand_vt    <= '0;
            cand_va    <= '0;
            prev_ht    <= '0;
            prev_ha    <= '0;
            prev_vt    <= '0;
            prev_va    <= '0;
            prev_valid <= 1'b0;
            stable_cnt <= '0;
            out_ht     <= '0;
            out_ha     <= '0;
            out_vt     <= '0;
            out_va     <= '0;
            locked_q   <= 1'b0;
            tchg_q     <= 1'b0;
        end else begin
            tchg_q <= 1'b0;
            if (hs_lead && state != ST_IDLE) begin
                if (line_cnt != '1) line_cnt <= line_cnt + 16'd1;
                if (de_cnt != '0 && act_cnt != '1) act_cnt <= act_cnt + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    line_cnt <= vs_lead ? {15'd0, hs_lead} : '0;
                    act_cnt  <= '0;
                    if (vs_lead) state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (vs_lead) begin
                        cand_vt  <= line_cnt;
                        cand_va  <= act_cnt + {15'd0, hs_lead && de_cnt != '0};
                        line_cnt <= {15'd0, hs_lead};
                        act_cnt  <= '0;
                        state    <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    prev_ht    <= cand_ht;
                    prev_ha    <= cand_ha;
                    prev_vt    <= cand_vt;
                    prev_va    <= cand_va;
                    prev_valid <= 1'b1;
                    stable_cnt <= stable_nxt;
                    if (stable_nxt == LOCK_N) begin
                        out_ht   <= cand_ht;
                        out_ha   <= cand_ha;
                        out_vt   <= cand_vt;
                        out_va   <= cand_va;
                        locked_q <= 1'b1;
                    end else if (locked_q) begin
                        locked_q <= 1'b0;
                        tchg_q   <= 1'b1;
                    end
                    state <= ST_MEASURE;
                end
                default: state <= ST_IDLE;
            endcase
            if (state != ST_IDLE && to_cnt == TIMEOUT - 24'd1 && !vs_lead) begin
                state      <= ST_IDLE;
                stable_cnt <= '0;
                prev_valid <= 1'b0;
                if (locked_q) begin
                    locked_q <= 1'b0;
                    tchg_q   <= 1'b1;
                end
            end
        end
    end

`ifdef VIN_TIMING_POL_DETECT_EN
    logic [15:0] hs_hi_cnt, vs_hi_lines;
    logic        hs_pol_new, vs_pol_new, vs_pol_upd;

    always_comb begin
        hs_pol_new = hs_hi_cnt < (h_cnt >> 1);
        vs_pol_new = vs_hi_lines < (line_cnt >> 1);
        vs_pol_upd = vs_lead && state == ST_MEASURE;
    end

    // pol_chg is held until the next COMPARE so the frame verdict sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pol_q    <= 1'b1;
            vs_pol_q    <= 1'b1;
            hs_hi_cnt   <= '0;
            vs_hi_lines <= '0;
            pol_chg     <= 1'b0;
        end else begin
            if (hs_lead) begin
                hs_hi_cnt <= {15'd0, hs2};
                hs_pol_q  <= hs_pol_new;
            end else if (hs2 && hs_hi_cnt != '1) begin
                hs_hi_cnt <= hs_hi_cnt + 16'd1;
            end
            if (vs_lead) vs_hi_lines <= {15'd0, hs_lead & vs2};
            else if (hs_lead && vs2 && vs_hi_lines != '1) vs_hi_lines <= vs_hi_lines + 16'd1;
            if (vs_pol_upd) vs_pol_q <= vs_pol_new;
            pol_chg <= (pol_chg && state != ST_COMPARE) ||
                       (hs_lead && hs_pol_new != hs_pol_q) ||
                       (vs_pol_upd && vs_pol_new != vs_pol_q);
        end
    end
`else
    always_comb begin
        hs_pol_q = 1'b1;
        vs_pol_q = 1'b1;
        pol_chg  = 1'b0;
    end
`endif

    assign vif.h_total       = out_ht;
    assign vif.h_active      = out_ha;
    assign vif.v_total       = out_vt;
    assign vif.v_active      = out_va;
    assign vif.hs_pol        = hs_pol_q;
    assign vif.vs_pol        = vs_pol_q;
    assign vif.locked        = locked_q;
    assign vif.timing_change = tchg_q;
    assign vif.frame_start   = vs_lead;
endmodule
